// File: rtl/il_pkg.sv
// il_pkg: shared constants and the permutation function for the 4x7 block
// interleaver.
//   IL_ROWS / IL_COLS : matrix geometry
//   IL_N              : word width, IL_ROWS*IL_COLS
//   il_perm(d, mode)  : mode 0 writes row-wise and reads column-wise;
//                       mode 1 is the exact inverse
package il_pkg;

    localparam int IL_ROWS = 4;
    localparam int IL_COLS = 7;
    localparam int IL_N    = IL_ROWS * IL_COLS;

    // Pure wiring permutation. Every output bit is assigned exactly once, so
    // the '0 default never reaches the result; it only keeps the function
    // free of unassigned bits.
    function automatic logic [IL_N-1:0] il_perm(input logic [IL_N-1:0] d,
                                                input logic            mode);
        logic [IL_N-1:0] q;
        q = '0;
        for (int r = 0; r < IL_ROWS; r++) begin
            for (int c = 0; c < IL_COLS; c++) begin
                if (mode == 1'b0) begin
                    q[c*IL_ROWS + r] = d[r*IL_COLS + c];
                end else begin
                    q[r*IL_COLS + c] = d[c*IL_ROWS + r];
                end
            end
        end
        return q;
    endfunction

endpackage

// File: rtl/il_perm_core.sv
// il_perm_core: combinational bit permutation feeding the interleaver's
// output register.
//   i_d    : input word
//   i_mode : 0 = interleave, 1 = deinterleave
//   o_q    : permuted word
module il_perm_core
    import il_pkg::*;
(
    input  logic [IL_N-1:0] i_d,
    input  logic            i_mode,
    output logic [IL_N-1:0] o_q
);

    // Permutation is wiring only: no arithmetic, no state.
    always_comb begin
        o_q = il_perm(i_d, i_mode);
    end

endmodule

// File: rtl/il_wrappers.sv
// interleaver / deinterleaver: thin wrappers fixing MODE on block_interleaver.
// Port order: clk, rst (async, active-low), en, data_in, en_out, data_out.
module interleaver
    import il_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [IL_N-1:0] data_in,
    output logic            en_out,
    output logic [IL_N-1:0] data_out
);

    block_interleaver #(.MODE(0)) u_core (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .data_in  (data_in),
        .en_out   (en_out),
        .data_out (data_out)
    );

endmodule

module deinterleaver
    import il_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [IL_N-1:0] data_in,
    output logic            en_out,
    output logic [IL_N-1:0] data_out
);

    block_interleaver #(.MODE(1)) u_core (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .data_in  (data_in),
        .en_out   (en_out),
        .data_out (data_out)
    );

endmodule

// File: rtl/block_interleaver.sv
// block_interleaver: fixed 4x7 row/column bit interleaver, one 28-bit word
// per clock with 1-clock latency.
//   clk      : rising-edge clock
//   rst      : asynchronous reset, active-low
//   en       : input word valid
//   data_in  : input word, bit 0 is the first bit of the block
//   en_out   : output word valid (en delayed by one clock)
//   data_out : permuted word, holds its value while en is low
// MODE selects interleave (0) or deinterleave (1).
module block_interleaver
    import il_pkg::*;
#(
    parameter  int ROWS = IL_ROWS,
    parameter  int COLS = IL_COLS,
    parameter  int MODE = 0,
    localparam int N    = ROWS * COLS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] data_in,
    output logic         en_out,
    output logic [N-1:0] data_out
);

    localparam logic MODE_BIT = (MODE != 0);

    logic [N-1:0] w_perm;
    logic         r_en_out;
    logic [N-1:0] r_data_out;

    il_perm_core u_perm_core (
        .i_d    (data_in),
        .i_mode (MODE_BIT),
        .o_q    (w_perm)
    );

    // Output stage: valid follows en, data captures only on valid words so
    // the last word stays visible across enable gaps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en_out   <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_en_out <= en;
            if (en) begin
                r_data_out <= w_perm;
            end else begin
                r_data_out <= r_data_out;
            end
        end
    end

    assign en_out   = r_en_out;
    assign data_out = r_data_out;

endmodule

// File: tb/tb_block_interleaver.sv
// tb_block_interleaver: directed self-checking bench for block_interleaver
// (MODE 0) plus an interleaver -> deinterleaver chain for the round trip.
module tb_block_interleaver;

    logic        clk;
    logic        rst;
    logic        en;
    logic [27:0] data_in;

    logic        en_out;
    logic [27:0] data_out;
    logic        il_en_out;
    logic [27:0] il_data_out;
    logic        dl_en_out;
    logic [27:0] dl_data_out;

    int n_tests;
    int n_fail;

    block_interleaver #(.MODE(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .data_in  (data_in),
        .en_out   (en_out),
        .data_out (data_out)
    );

    interleaver u_il (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .data_in  (data_in),
        .en_out   (il_en_out),
        .data_out (il_data_out)
    );

    deinterleaver u_dl (
        .clk      (clk),
        .rst      (rst),
        .en       (il_en_out),
        .data_in  (il_data_out),
        .en_out   (dl_en_out),
        .data_out (dl_data_out)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [27:0] got,
                            input logic [27:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [27:0] exp_walk;
        n_tests = 0;
        n_fail  = 0;

        // Reset held with live input: outputs must stay at zero.
        rst     = 1'b0;
        en      = 1'b1;
        data_in = 28'h3E1EDE5;
        #1;
        check_eq("rst_en_t0",   {27'd0, en_out}, 28'd0);
        check_eq("rst_data_t0", data_out,        28'd0);
        step();
        check_eq("rst_en_t1",   {27'd0, en_out}, 28'd0);
        check_eq("rst_data_t1", data_out,        28'd0);
        step();
        check_eq("rst_dl_en",   {27'd0, dl_en_out}, 28'd0);
        check_eq("rst_dl_data", dl_data_out,        28'd0);

        // Interleave 28'h3E1EDE5; hand-derived column-wise read gives 28'h31AADEF.
        rst = 1'b1;
        step();
        check_eq("il_en",      {27'd0, en_out}, 28'd1);
        check_eq("il_data",    data_out,        28'h31AADEF);
        check_eq("il_wrap",    il_data_out,     28'h31AADEF);
        step();
        check_eq("rt_en",      {27'd0, dl_en_out}, 28'd1);
        check_eq("rt_data",    dl_data_out,        28'h3E1EDE5);
        step();
        check_eq("rt_hold",    dl_data_out,        28'h3E1EDE5);

        // Whole rows map onto one bit of every column nibble.
        data_in = 28'h000007F;
        step();
        check_eq("row0", data_out, 28'h1111111);
        data_in = 28'h01FC000;
        step();
        check_eq("row2", data_out, 28'h4444444);
        step();
        check_eq("row2_rt", dl_data_out, 28'h01FC000);
        data_in = 28'hFE00000;
        step();
        check_eq("row3", data_out, 28'h8888888);

        // Named single-bit cases.
        data_in = 28'h0000002;
        step();
        check_eq("bit_k1", data_out, 28'h0000010);
        data_in = 28'h0000080;
        step();
        check_eq("bit_k7", data_out, 28'h0000002);

        // Single-bit walk: bit k lands at (k%7)*4 + k/7.
        for (int k = 0; k < 28; k++) begin
            data_in  = 28'd1 << k;
            exp_walk = 28'd0;
            exp_walk[(k % 7) * 4 + k / 7] = 1'b1;
            step();
            check_eq($sformatf("walk_k%0d", k), data_out, exp_walk);
        end

        // Enable gap: A, three idle clocks with junk data, then B.
        data_in = 28'h000007F;
        en      = 1'b1;
        step();
        check_eq("gap_a", data_out, 28'h1111111);
        for (int g = 0; g < 3; g++) begin
            en      = 1'b0;
            data_in = 28'hABCDEF0 ^ 28'(g);
            step();
            check_eq($sformatf("gap_en%0d", g),   {27'd0, en_out}, 28'd0);
            check_eq($sformatf("gap_hold%0d", g), data_out,        28'h1111111);
        end
        en      = 1'b1;
        data_in = 28'hFE00000;
        step();
        check_eq("gap_b_en", {27'd0, en_out}, 28'd1);
        check_eq("gap_b",    data_out,        28'h8888888);

        // Mid-stream reset between edges clears outputs asynchronously.
        data_in = 28'h01FC000;
        step();
        check_eq("mid_pre", data_out, 28'h4444444);
        #2;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_en",   {27'd0, en_out}, 28'd0);
        check_eq("mid_rst_data", data_out,        28'd0);
        check_eq("mid_rst_dl",   dl_data_out,     28'd0);
        step();
        check_eq("mid_rst_hold", data_out, 28'd0);
        rst = 1'b1;
        step();
        check_eq("mid_post_en", {27'd0, en_out}, 28'd1);
        check_eq("mid_post",    data_out,        28'h4444444);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
